// File: rtl/div32x32_pkg.sv
// Shared definitions for the div32x32_fast divider: FSM states, iteration
// counts and the quotient reported for a zero divisor.
package div32x32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_e;

    localparam logic [4:0]  ITER_FULL     = 5'd31;
    localparam logic [4:0]  ITER_HALF     = 5'd15;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    // A dividend that fits in 16 bits only needs half the restoring steps.
    function automatic logic is_short_dividend(input logic [31:0] value);
        return (value[31:16] == 16'd0);
    endfunction

endpackage : div32x32_pkg

// File: rtl/div32x32_fast_arith.sv
// Restoring-division datapath: partial remainder, shifting quotient/dividend
// register, 33-bit trial subtraction and iteration counter.
module div32x32_fast_arith
    import div32x32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [4:0]  count_o,
    output logic [31:0] quot_next_o,
    output logic [31:0] rem_next_o
);

    logic [31:0] rem_q;
    logic [31:0] q_work_q;
    logic [31:0] divisor_q;
    logic [4:0]  count_q;

    logic [32:0] partial_s;
    logic [32:0] diff_s;
    logic        fits_s;
    logic [31:0] rem_step_s;
    logic [31:0] q_step_s;

    // One restoring step. rem < divisor always holds, so partial < 2*divisor
    // and the borrow bit of the 33-bit difference is exactly (partial < divisor).
    always_comb begin
        partial_s = {rem_q, q_work_q[31]};
        diff_s    = partial_s - {1'b0, divisor_q};
        fits_s    = ~diff_s[32];
        if (fits_s) begin
            rem_step_s = diff_s[31:0];
        end else begin
            rem_step_s = partial_s[31:0];
        end
        q_step_s = {q_work_q[30:0], fits_s};
    end

    // Datapath registers: load on an accepted start, shift once per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q     <= 32'd0;
            q_work_q  <= 32'd0;
            divisor_q <= 32'd0;
            count_q   <= 5'd0;
        end else if (load_i) begin
            rem_q     <= 32'd0;
            divisor_q <= divisor_i;
            if (is_short_dividend(dividend_i)) begin
                q_work_q <= {dividend_i[15:0], 16'd0};
                count_q  <= ITER_HALF;
            end else begin
                q_work_q <= dividend_i;
                count_q  <= ITER_FULL;
            end
        end else if (step_i) begin
            rem_q    <= rem_step_s;
            q_work_q <= q_step_s;
            if (count_q != 5'd0) begin
                count_q <= count_q - 5'd1;
            end else begin
                count_q <= 5'd0;
            end
        end else begin
            rem_q     <= rem_q;
            q_work_q  <= q_work_q;
            divisor_q <= divisor_q;
            count_q   <= count_q;
        end
    end

    assign count_o     = count_q;
    assign quot_next_o = q_step_s;
    assign rem_next_o  = rem_step_s;

endmodule : div32x32_fast_arith

// File: rtl/div32x32_fast.sv
// 32/32 unsigned iterative divider with a 16-step fast path for short
// dividends and a one-cycle divide-by-zero path.
module div32x32_fast
    import div32x32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    state_e      state_q, state_d;
    logic        busy_q;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] zero_a_q, zero_a_d;
    logic        dbz_q, dbz_d;

    logic        load_s;
    logic        step_s;
    logic [4:0]  count_s;
    logic [31:0] quot_next_s;
    logic [31:0] rem_next_s;

    div32x32_fast_arith u_arith (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_s),
        .step_i      (step_s),
        .dividend_i  (a),
        .divisor_i   (b),
        .count_o     (count_s),
        .quot_next_o (quot_next_s),
        .rem_next_o  (rem_next_s)
    );

    // Control FSM: results are written only on the final step or on ZERO exit.
    always_comb begin
        state_d  = state_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        zero_a_d = zero_a_q;
        dbz_d    = dbz_q;
        load_s   = 1'b0;
        step_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (b != 32'd0) begin
                        load_s  = 1'b1;
                        quot_d  = 32'd0;
                        rem_d   = 32'd0;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        zero_a_d = a;
                        state_d  = ZERO;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (count_s == 5'd0) begin
                    quot_d  = quot_next_s;
                    rem_d   = rem_next_s;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            ZERO: begin
                quot_d  = DIV_ZERO_QUOT;
                rem_d   = zero_a_q;
                dbz_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; busy is registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            quot_q   <= 32'd0;
            rem_q    <= 32'd0;
            zero_a_q <= 32'd0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d != IDLE);
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            zero_a_q <= zero_a_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule : div32x32_fast

// File: tb/tb_div32x32_fast.sv
// Self-checking bench for div32x32_fast: directed table, randomized operands
// against an arithmetic reference, and hand-written busy/reset sequences.
module tb_div32x32_fast;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    div32x32_fast dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic from the divider's contract.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dbz, output int cyc);
        if (mb == 32'd0) begin
            q = 32'hFFFF_FFFF; r = ma; dbz = 1'b1; cyc = 1;
        end else begin
            q = ma / mb; r = ma % mb; dbz = 1'b0;
            cyc = (ma < 32'h0001_0000) ? 16 : 32;
        end
    endtask

    // Count negedges with busy=1 (bounded); ends on the first negedge busy=0.
    task automatic wait_done(inout int cyc);
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    // Called at a negedge; drives a one-cycle start then scrambles operands.
    task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_v, output int cyc);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
        cyc = 0;
        wait_done(cyc);
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] ta, input logic [31:0] tb_v);
        logic [31:0] eq, er;
        logic        ed;
        int          ec, cyc;
        model(ta, tb_v, eq, er, ed, ec);
        run_div(ta, tb_v, cyc);
        check({tag, "_cycles"}, cyc, ec);
        check({tag, "_quot"}, quotient, eq);
        check({tag, "_rem"}, remainder, er);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ed});
    endtask

    initial begin
        logic [31:0] ra, rb, hq, hr;
        int          cyc;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 16};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 32};
        vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 32};
        vecs[3] = '{32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 1};
        vecs[4] = '{32'h0000_FFFF,  32'h0000_FFFF,  32'd1,          32'd0,          1'b0, 16};
        vecs[5] = '{32'h0001_0000,  32'd3,          32'd21845,      32'd1,          1'b0, 32};
        vecs[6] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 16};
        vecs[7] = '{32'd7,          32'h8000_0001,  32'd0,          32'd7,          1'b0, 16};

        reset = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_quot", quotient, 32'd0);
        check("reset_rem", remainder, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table; consecutive calls also exercise start on the busy-fall cycle.
        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].a, vecs[i].b, cyc);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
            check($sformatf("vec%0d_quot", i), quotient, vecs[i].q);
            check($sformatf("vec%0d_rem", i), remainder, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
        end

        // Results hold while idle.
        hq = quotient; hr = remainder;
        repeat (5) @(negedge clk);
        check("hold_quot", quotient, 32'd0);
        check("hold_rem", remainder, 32'd7);
        check("hold_quot_stable", quotient, hq);
        check("hold_rem_stable", remainder, hr);

        // Second start mid-division is ignored.
        a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 5) begin
                start = 1'b1; a = 32'd9; b = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_cycles", cyc, 16);
        check("ignore_quot", quotient, 32'd333);
        check("ignore_rem", remainder, 32'd1);

        // Reset mid-division discards everything.
        a = 32'hDEAD_BEEF; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 10) begin
            cyc++;
            if (cyc < 10) @(negedge clk);
        end
        check("midreset_reached", cyc, 10);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_quot", quotient, 32'd0);
        check("midreset_rem", remainder, 32'd0);
        check("midreset_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_and_check("after_reset", 32'd50, 32'd5);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 5)
                0: ra = ra & 32'h0000_FFFF;
                1: rb = rb & 32'h0000_00FF;
                2: rb = rb | 32'h8000_0000;
                3: if (i % 15 == 3) rb = 32'd0;
                default: ;
            endcase
            run_and_check("rand", ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div32x32_fast
